mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb.sv | 183 ++++++++++++++++++
 tb/tb_mem_arb.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb.sv
// mem_arb: arbitrates a CPU and a DMA requester onto one asynchronous SRAM port.
// Each access runs SETUP, ACCESS (WAIT_CYCLES), DONE. MEM_ARB_RR_EN selects round-robin; default is CPU priority.
module mem_arb #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset_bar,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [15:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [15:0] dma_wdata,
  output logic        dma_ack,
  output logic [15:0] dma_rdata,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        mem_we_bar,
  output logic        mem_oe_bar,
  output logic        busy
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYCLES - 1);
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dma_rdata_q, dma_rdata_d;
  logic          we_bar_q, we_bar_d;
  logic          oe_bar_q, oe_bar_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          dma_ack_q, dma_ack_d;
  logic          busy_q, busy_d;
  logic          grant_dma_c;
`ifdef MEM_ARB_RR_EN
  logic          last_q, last_d;
`endif

  // Which requester wins when the FSM samples in IDLE
  always_comb begin
`ifdef MEM_ARB_RR_EN
    if (cpu_req && dma_req) begin
      grant_dma_c = ~last_q;
    end else begin
      grant_dma_c = dma_req;
    end
`else
    grant_dma_c = ~cpu_req;
`endif
  end

  // Next state, latched request and registered outputs (decoded from next state)
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
`ifdef MEM_ARB_RR_EN
    last_d      = last_q;
`endif

    case (state_q)
      IDLE: begin
        if (cpu_req || dma_req) begin
          owner_d = grant_dma_c;
          we_d    = grant_dma_c ? dma_we    : cpu_we;
          addr_d  = grant_dma_c ? dma_addr  : cpu_addr;
          wdata_d = grant_dma_c ? dma_wdata : cpu_wdata;
          state_d = SETUP;
`ifdef MEM_ARB_RR_EN
          last_d  = grant_dma_c;
`endif
        end
      end
      SETUP: begin
        cnt_d   = WAIT_LAST;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          if (!we_q) begin
            if (owner_q == OWN_DMA) begin
              dma_rdata_d = mem_rdata;
            end else begin
              cpu_rdata_d = mem_rdata;
            end
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Strobes are a pure decode of the coming state, so they never overlap
    we_bar_d  = !((state_d == ACCESS) && we_d);
    oe_bar_d  = !((state_d == ACCESS) && !we_d);
    cpu_ack_d = (state_d == DONE) && (owner_d == OWN_CPU);
    dma_ack_d = (state_d == DONE) && (owner_d == OWN_DMA);
    busy_d    = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_q     <= OWN_CPU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      we_bar_q    <= 1'b1;
      oe_bar_q    <= 1'b1;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_q      <= OWN_DMA;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      we_bar_q    <= we_bar_d;
      oe_bar_q    <= oe_bar_d;
      cpu_ack_q   <= cpu_ack_d;
      dma_ack_q   <= dma_ack_d;
      busy_q      <= busy_d;
`ifdef MEM_ARB_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_we_bar = we_bar_q;
  assign mem_oe_bar = oe_bar_q;
  assign cpu_ack    = cpu_ack_q;
  assign dma_ack    = dma_ack_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dma_rdata  = dma_rdata_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mem_arb.sv
// Testbench for mem_arb: SRAM model plus a transaction-level expectation of strobe windows, acks and read data.
module tb_mem_arb;

  localparam int unsigned W = 3;

  logic        clk = 1'b0;
  logic        reset_bar;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic        cpu_ack, dma_ack, mem_we_bar, mem_oe_bar, busy;
  logic [15:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;

  logic [15:0] ram     [0:255];
  logic [15:0] ref_mem [0:255];
  logic [15:0] exp_cpu_rd, exp_dma_rd;
  int          total, bad;

  always #5 clk = ~clk;

  mem_arb #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .reset_bar(reset_bar),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_we_bar(mem_we_bar), .mem_oe_bar(mem_oe_bar), .busy(busy)
  );

  function automatic logic [15:0] init_val(input int i);
    if (i == 16) return 16'h5A5A;
    return 16'(i * 40503) ^ 16'h3C96;
  endfunction

  // Asynchronous SRAM: combinational read, write on clock edges while the strobe is low
  assign mem_rdata = ram[mem_addr[7:0]];
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (mem_we_bar === 1'b0) ram[mem_addr[7:0]] = mem_wdata;
    end
  end

  task automatic test_reset;
    logic [68:0] obs;
    reset_bar = 1'b1;
    #2 reset_bar = 1'b0;
    #1;
    obs = {busy, mem_we_bar, mem_oe_bar, cpu_ack, dma_ack, mem_addr, mem_wdata, cpu_rdata, dma_rdata};
    total++;
    if (obs !== {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0}) begin
      bad++;
      $display("FAIL reset_state got=%h want=%h", obs, {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0});
    end
    @(negedge clk);
    @(negedge clk);
    reset_bar = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, mem_we_bar, mem_oe_bar, cpu_ack, dma_ack} !== 5'b01100) begin
      bad++;
      $display("FAIL reset_idle got=%b want=01100", {busy, mem_we_bar, mem_oe_bar, cpu_ack, dma_ack});
    end
  endtask

  // One access by a single requester, checked every cycle; optionally disturbs the inputs mid-access
  task automatic test_single_access(input bit who, input bit we, input logic [15:0] addr,
                                    input logic [15:0] wdata, input bit scramble);
    logic [36:0] obs, exp;
    bit in_acc;
    if (who) begin
      dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end
    @(posedge clk);
    for (int k = 1; k <= int'(W) + 2; k++) begin
      @(negedge clk);
      if (scramble && k == 2) begin
        if (who) begin
          dma_req = 1'b0; dma_we = ~we; dma_addr = addr + 16'd1; dma_wdata = ~wdata;
        end else begin
          cpu_req = 1'b0; cpu_we = ~we; cpu_addr = addr + 16'd1; cpu_wdata = ~wdata;
        end
      end
      if (k == int'(W) + 2 && !we) begin
        if (who) exp_dma_rd = ref_mem[addr[7:0]];
        else     exp_cpu_rd = ref_mem[addr[7:0]];
      end
      in_acc = (k >= 2) && (k <= int'(W) + 1);
      exp = {1'b1, !(we && in_acc), !(!we && in_acc), (k == int'(W) + 2) && !who,
             (k == int'(W) + 2) && who, addr, wdata};
      obs = {busy, mem_we_bar, mem_oe_bar, cpu_ack, dma_ack, mem_addr, mem_wdata};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL access_cycle k=%0d who=%0d we=%0d got=%h want=%h", k, who, we, obs, exp);
      end
      total++;
      if ({cpu_rdata, dma_rdata} !== {exp_cpu_rd, exp_dma_rd}) begin
        bad++;
        $display("FAIL rdata k=%0d got=%h want=%h", k, {cpu_rdata, dma_rdata}, {exp_cpu_rd, exp_dma_rd});
      end
    end
    if (we) ref_mem[addr[7:0]] = wdata;
    cpu_req = 1'b0;
    dma_req = 1'b0;
    @(negedge clk);
    obs = {busy, mem_we_bar, mem_oe_bar, cpu_ack, dma_ack, mem_addr, mem_wdata};
    exp = {5'b01100, addr, wdata};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL idle_hold got=%h want=%h", obs, exp);
    end
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      test_single_access(1'($urandom), 1'($urandom),
                         {8'($urandom), 8'($urandom_range(0, 254))}, 16'($urandom),
                         ($urandom_range(0, 3) == 0));
    end
  endtask

  // Both requesters held high; grants and ack spacing follow the arbitration policy
  task automatic test_arbitration;
    int  n_neg, exp_at;
    int  ack_at[$];
    bit  who_q[$];
    bit  exp_who;
    @(negedge clk);
    reset_bar = 1'b0;
    exp_cpu_rd = '0;
    exp_dma_rd = '0;
    @(negedge clk);
    reset_bar = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0021; cpu_wdata = 16'h1111;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0042; dma_wdata = 16'h2222;
    n_neg = 0;
    while (who_q.size() < 4 && n_neg < 4 * (int'(W) + 3) + 4) begin
      @(negedge clk);
      n_neg++;
      if (cpu_ack || dma_ack) begin
        if (dma_ack) exp_dma_rd = ref_mem[8'h42];
        else         exp_cpu_rd = ref_mem[8'h21];
        who_q.push_back(dma_ack);
        ack_at.push_back(n_neg);
        total++;
        if ((cpu_ack && dma_ack) || {cpu_rdata, dma_rdata} !== {exp_cpu_rd, exp_dma_rd}) begin
          bad++;
          $display("FAIL arb_ack acks=%b rdata=%h want=%h", {cpu_ack, dma_ack},
                   {cpu_rdata, dma_rdata}, {exp_cpu_rd, exp_dma_rd});
        end
      end
    end
    cpu_req = 1'b0;
    dma_req = 1'b0;
    total++;
    if (who_q.size() != 4) begin
      bad++;
      $display("FAIL arb_timeout grants=%0d want=4", who_q.size());
    end
    for (int i = 0; i < who_q.size(); i++) begin
`ifdef MEM_ARB_RR_EN
      exp_who = (i % 2) == 1;
`else
      exp_who = 1'b0;
`endif
      exp_at = int'(W) + 2 + i * (int'(W) + 3);
      total++;
      if (who_q[i] !== exp_who || ack_at[i] != exp_at) begin
        bad++;
        $display("FAIL arb_grant%0d who=%0d at=%0d want who=%0d at=%0d", i, who_q[i], ack_at[i],
                 exp_who, exp_at);
      end
    end
    @(negedge clk);
  endtask

  // Reset pulse in the middle of a write aborts it cleanly
  task automatic test_reset_mid;
    logic [68:0] obs;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h00FF; cpu_wdata = 16'($urandom);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (mem_we_bar !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_strobe got=%b want=0", mem_we_bar);
    end
    #2 reset_bar = 1'b0;
    cpu_req = 1'b0;
    exp_cpu_rd = '0;
    exp_dma_rd = '0;
    for (int j = 0; j < 3; j++) begin
      if (j > 0) @(posedge clk);
      #1;
      obs = {busy, mem_we_bar, mem_oe_bar, cpu_ack, dma_ack, mem_addr, mem_wdata, cpu_rdata, dma_rdata};
      total++;
      if (obs !== {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0}) begin
        bad++;
        $display("FAIL reset_mid%0d got=%h want=%h", j, obs, {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0});
      end
    end
    @(negedge clk);
    reset_bar = 1'b1;
    test_single_access(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    exp_cpu_rd = '0;
    exp_dma_rd = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;

    test_reset;
    test_single_access(1'b0, 1'b1, 16'h1234, 16'hBEEF, 1'b0);
    test_single_access(1'b0, 1'b0, 16'h1234, 16'h0000, 1'b0);
    test_single_access(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
    test_single_access(1'b0, 1'b0, 16'h0001, 16'h0000, 1'b1);
    test_random(40);
    test_arbitration;
    test_reset_mid;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
